// File: rtl/cmul_result_fifo_if.sv
// Handshake bundle between the constant multiplier, the result FIFO and its consumer.
// slave: the FIFO side. master: the producer/consumer side.
interface cmul_result_fifo_if #(
  parameter int N = 4
);
  localparam int DW = 2**N;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] mul_result;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_valid, mul_result, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_valid, mul_result, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/cmul_result_fifo.sv
// Result buffer behind the non-stalling ~1/sqrt2 multiplier: tracks operand validity
// through the LAT-cycle pipeline, stores results in a FWFT FIFO, and reserves room for in-flight samples.
module cmul_result_fifo #(
  parameter int N     = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  cmul_result_fifo_if.slave   bus,
  output logic [AW:0]         count,
  output logic                err,
  output logic                overflow
);
  localparam int          DW   = 2**N;
  localparam int          IW   = $clog2(LAT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LAT-1:0] vd;
  logic [IW-1:0]  inflight;
  logic [AW+1:0]  reserved;
  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           wr_req;
  logic           rd;
  logic           wr;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight = inflight + IW'(vd[i]);
    end
  end

  // Space already promised to in-flight samples counts as used; a same-cycle read does not help.
  assign reserved      = (AW+2)'(count) + (AW+2)'(inflight);
  assign bus.in_ready  = reserved < (AW+2)'(DEPTH);

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];

  assign wr_req = vd[LAT-1];
  assign rd     = bus.out_valid && bus.out_ready;
  assign wr     = wr_req && ((count < FULL) || rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vd       <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err      <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      vd[0] <= bus.in_valid;
      for (int unsigned i = 1; i < LAT; i++) begin
        vd[i] <= vd[i-1];
      end

      if (wr) begin
        mem[wr_ptr] <= bus.mul_result;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (bus.in_valid && !bus.in_ready) begin
        err <= 1'b1;
      end
      if (wr_req && !wr) begin
        overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cmul_result_fifo.sv
// Bench for cmul_result_fifo: a behavioural multiplier feeds the DUT, and a queue-based
// reference model predicts FIFO contents, handshake and sticky flags every cycle.
module tb_cmul_result_fifo;
  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   count;
  logic          err;
  logic          overflow;
  logic [DW-1:0] a_in;
  logic [DW-1:0] pipe [LAT];

  int ntests = 0;
  int nfail  = 0;

  cmul_result_fifo_if #(.N(N)) bus ();

  cmul_result_fifo #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .err      (err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mulf(input logic [DW-1:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'h5A80;
    return p[30:15];
  endfunction

  // Stand-in for the upstream multiplier: result appears LAT cycles after its operand.
  always @(posedge clk) begin
    pipe[0] <= mulf(a_in);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mul_result = pipe[LAT-1];

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] d;
  } pend_t;

  pend_t         pend[$];
  logic [DW-1:0] mq[$];
  bit            merr;
  bit            movf;
  int unsigned   cyc = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    mq.delete();
    merr = 0;
    movf = 0;
  endtask

  function automatic bit model_ready();
    return (mq.size() + pend.size()) < DEPTH;
  endfunction

  task automatic step();
    bit mrd;
    if (!rst) begin
      model_clear();
    end else begin
      mrd = (mq.size() != 0) && bus.out_ready;
      if (bus.in_valid && !model_ready()) merr = 1;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        if (mq.size() < DEPTH || mrd) mq.push_back(pend[0].d);
        else movf = 1;
        void'(pend.pop_front());
      end
      if (mrd) void'(mq.pop_front());
      if (bus.in_valid) pend.push_back('{cyc + LAT, mulf(a_in)});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic compare_all();
    chk("out_valid", bus.out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("out_data", bus.out_data, mq[0]);
    chk("count", count, mq.size());
    chk("in_ready", bus.in_ready, model_ready());
    chk("err", err, merr);
    chk("overflow", overflow, movf);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_out_data"}, bus.out_data, 0);
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    chk({nm, "_count"}, count, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_overflow"}, overflow, 0);
  endtask

  typedef struct {
    bit            iv;
    logic [DW-1:0] a;
    bit            ordy;
    bit            ov;
    logic [DW-1:0] d;
    int unsigned   cnt;
    bit            ir;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int          accepted;
    int          n_out;
    int unsigned first_out;
    int unsigned last_out;
    logic [DW-1:0] head;

    // record i: inputs for cycle i; expectations for cycle i+1
    tbl[0]  = '{1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000, 0, 1'b1};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h5A80, 1, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b1};
    tbl[5]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 0, 1'b1};
    tbl[6]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 0, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 2, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hB4FF, 1, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1};

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    a_in          = '0;
    model_clear();
    #1;
    chk_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // single samples and a back-to-back pair
    for (int i = 0; i < 11; i++) begin
      bus.in_valid  = tbl[i].iv;
      a_in          = tbl[i].a;
      bus.out_ready = tbl[i].ordy;
      step();
      chk("tbl_out_valid", bus.out_valid, tbl[i].ov);
      if (tbl[i].ov) chk("tbl_out_data", bus.out_data, tbl[i].d);
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_in_ready", bus.in_ready, tbl[i].ir);
    end

    // streaming
    n_out = 0;
    first_out = 0;
    last_out = 0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      bus.in_valid = (i <= 20);
      a_in = (i <= 20) ? DW'(i) : '0;
      step();
      compare_all();
      chk("stream_count_le1", count <= 1, 1);
      chk("stream_in_ready", bus.in_ready, 1);
      if (bus.out_valid) begin
        if (n_out == 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
    end
    chk("stream_n_out", n_out, 20);
    chk("stream_span", last_out - first_out, 19);

    // fill with producer obeying in_ready
    accepted = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 14; k++) begin
      bus.in_valid = bus.in_ready;
      a_in = DW'($urandom);
      if (bus.in_valid) accepted++;
      step();
      compare_all();
      if (accepted == 8 && bus.in_valid) chk("fill_ready_drop", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    chk("fill_accepted", accepted, 8);
    chk("fill_count", count, 8);
    chk("fill_overflow", overflow, 0);

    // forced violation against a full FIFO
    head = mq[0];
    bus.in_valid = 1'b1;
    a_in = 16'h1234;
    step();
    bus.in_valid = 1'b0;
    compare_all();
    chk("viol_err", err, 1);
    chk("viol_overflow_early", overflow, 0);
    for (int k = 0; k < LAT; k++) begin
      step();
      compare_all();
    end
    chk("viol_overflow", overflow, 1);
    chk("viol_count", count, 8);
    chk("viol_head", bus.out_data, head);

    // drain in order
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      compare_all();
    end
    chk("drain_count", count, 0);

    // reset with 4 stored and 2 in flight
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      a_in = DW'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    compare_all();
    chk("mid_count4", count, 4);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_clear();
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      compare_all();
      chk("post_rst_count", count, 0);
      chk("post_rst_out_valid", bus.out_valid, 0);
    end

    // random traffic, producer obeying in_ready
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = bus.in_ready && ($urandom_range(2) != 0);
      bus.out_ready = $urandom_range(1);
      a_in          = DW'($urandom);
      step();
      compare_all();
    end

    // random traffic with a misbehaving producer and slow consumer
    for (int k = 0; k < 60; k++) begin
      bus.in_valid  = $urandom_range(1);
      bus.out_ready = ($urandom_range(3) == 0);
      a_in          = DW'($urandom);
      step();
      compare_all();
    end

    // reset while idle
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_idle");
    model_clear();
    step();
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
